u110_buffer_seq: RTL and testbench

Registered successor to the U110 buffer-control logic.
- Drives per-channel ATA buffer enables with a guaranteed dead cycle on every direction or channel change.
- Tracks 68040-style transfers, including a beat counter for line (SIZ=11) bursts.
- Sequences CPU↔PCI ownership of the unidirectional busses with a break-before-make turnaround, instead of a static BUSDIR.

---
 rtl/u110_buffer_seq.sv | 175 +++++++++++++++++
 tb/tb_u110_buffer_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/u110_buffer_seq.sv
// Registered U110 buffer control: 68040 transfer tracking, CPU/PCI bus ownership
// with break-before-make turnaround, and ATA buffer enables with a dead cycle on change.
module u110_buffer_seq #(
  parameter int NUM_CH      = 2,
  parameter int TURN_CYC    = 2,
  parameter int BURST_BEATS = 4,
  parameter int LOW_EN      = 0
) (
  input  logic                           CLK40,
  input  logic                           RESETn,
  input  logic [NUM_CH-1:0]              ATA_ENn,
  input  logic                           RnW,
  input  logic                           TSn,
  input  logic                           TAn,
  input  logic [1:0]                     SIZ,
  input  logic                           BGn,
  output logic [NUM_CH-1:0]              IDEHRENn,
  output logic [NUM_CH-1:0]              IDEHWENn,
  output logic [NUM_CH-1:0]              IDELENn,
  output logic                           IDEDIR,
  output logic                           BURSTn,
  output logic                           LASTn,
  output logic [$clog2(BURST_BEATS)-1:0] BEAT,
  output logic                           BUSDIR,
  output logic                           BUSOEn,
  output logic                           BUSY
);

  localparam int BW  = $clog2(BURST_BEATS);
  localparam int TW  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_BEATS - 1);
  localparam logic [TW-1:0] TURN_MAX = TW'(TURN_CYC - 1);

  typedef enum logic [1:0] {CPU_OWN, TURN_PCI, PCI_OWN, TURN_CPU} own_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} ata_t;

  logic          busy, burstn, lastn;
  logic [BW-1:0] beat, beat_inc;
  own_t          own, own_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  ata_t          ata, ata_nxt;
  logic [CHW-1:0] ch, sel_idx;
  logic          rnw, idedir, req, load, dir_ld;
  int            nlow;

  // Transfer tracker: a burst is remembered through burstn until its final beat
  assign beat_inc = beat + 1'b1;

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      busy   <= 1'b0;
      beat   <= '0;
      burstn <= 1'b1;
      lastn  <= 1'b1;
    end else if (!busy) begin
      if (!TSn) begin
        busy   <= 1'b1;
        beat   <= '0;
        burstn <= (SIZ != 2'b11);
        lastn  <= (SIZ == 2'b11);
      end
    end else if (!TAn) begin
      if (burstn || (beat == BEAT_MAX)) begin
        busy   <= 1'b0;
        beat   <= '0;
        burstn <= 1'b1;
        lastn  <= 1'b1;
      end else begin
        beat  <= beat_inc;
        lastn <= (beat_inc != BEAT_MAX);
      end
    end
  end

  // Ownership FSM; a new transfer in the grant cycle defers the handover
  always_comb begin
    own_nxt  = own;
    tcnt_nxt = '0;
    case (own)
      CPU_OWN:  if (!BGn && !busy && TSn) own_nxt = TURN_PCI;
      TURN_PCI: if (tcnt == TURN_MAX) own_nxt = PCI_OWN; else tcnt_nxt = tcnt + 1'b1;
      PCI_OWN:  if (BGn) own_nxt = TURN_CPU;
      TURN_CPU: if (tcnt == TURN_MAX) own_nxt = CPU_OWN; else tcnt_nxt = tcnt + 1'b1;
      default:  own_nxt = CPU_OWN;
    endcase
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      own  <= CPU_OWN;
      tcnt <= '0;
    end else begin
      own  <= own_nxt;
      tcnt <= tcnt_nxt;
    end
  end

  assign BUSOEn = (own == TURN_PCI) || (own == TURN_CPU);
  assign BUSDIR = (own == PCI_OWN) || (own == TURN_CPU);

  // ATA select decode: anything other than exactly one low select is no request
  always_comb begin
    nlow    = 0;
    sel_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!ATA_ENn[i]) begin
        sel_idx = CHW'(i);
        nlow    = nlow + 1;
      end
    end
    req = (nlow == 1) && (own == CPU_OWN) && RESETn;
  end

  always_comb begin
    ata_nxt = ata;
    load    = 1'b0;
    dir_ld  = 1'b0;
    case (ata)
      IDLE: if (req) begin
        ata_nxt = ACTIVE;
        load    = 1'b1;
        dir_ld  = 1'b1;
      end
      ACTIVE: if (!req || (sel_idx != ch) || (RnW != rnw)) begin
        ata_nxt = GAP;
        dir_ld  = req;
      end
      GAP: if (req) begin
        ata_nxt = ACTIVE;
        load    = 1'b1;
        dir_ld  = 1'b1;
      end else begin
        ata_nxt = IDLE;
      end
      default: ata_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      ata    <= IDLE;
      idedir <= 1'b0;
    end else begin
      ata <= ata_nxt;
      if (dir_ld) idedir <= !RnW;
    end
  end

  always_ff @(posedge CLK40) begin
    if (load) begin
      ch  <= sel_idx;
      rnw <= RnW;
    end
  end

  // Enables drop the instant ownership leaves the CPU, ahead of the FSM reaching GAP
  always_comb begin
    IDEHRENn = '1;
    IDEHWENn = '1;
    IDELENn  = '1;
    if ((ata == ACTIVE) && (own == CPU_OWN)) begin
      if (rnw) IDEHRENn[ch] = 1'b0;
      else     IDEHWENn[ch] = 1'b0;
      if (LOW_EN != 0) IDELENn[ch] = 1'b0;
    end
  end

  assign IDEDIR = idedir;
  assign BURSTn = burstn;
  assign LASTn  = lastn;
  assign BEAT   = beat;
  assign BUSY   = busy;

endmodule

// File: tb/tb_u110_buffer_seq.sv
// Directed bench for u110_buffer_seq: transfer tracking, reset, ATA gap sequencing
// and CPU/PCI ownership turnaround with hand-computed expectations.
module tb_u110_buffer_seq;

  logic       CLK40 = 1'b0;
  logic       RESETn;
  logic [1:0] ATA_ENn;
  logic       RnW, TSn, TAn, BGn;
  logic [1:0] SIZ;
  logic [1:0] IDEHRENn, IDEHWENn, IDELENn;
  logic       IDEDIR, BURSTn, LASTn, BUSDIR, BUSOEn, BUSY;
  logic [1:0] BEAT;

  int checks = 0;
  int errors = 0;

  u110_buffer_seq #(.NUM_CH(2), .TURN_CYC(2), .BURST_BEATS(4), .LOW_EN(1)) dut (
    .CLK40(CLK40), .RESETn(RESETn), .ATA_ENn(ATA_ENn), .RnW(RnW), .TSn(TSn),
    .TAn(TAn), .SIZ(SIZ), .BGn(BGn), .IDEHRENn(IDEHRENn), .IDEHWENn(IDEHWENn),
    .IDELENn(IDELENn), .IDEDIR(IDEDIR), .BURSTn(BURSTn), .LASTn(LASTn),
    .BEAT(BEAT), .BUSDIR(BUSDIR), .BUSOEn(BUSOEn), .BUSY(BUSY)
  );

  always #5 CLK40 = ~CLK40;

  task automatic tick();
    @(posedge CLK40);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hr"}, 8'(IDEHRENn), 8'h3);
    chk({tag, "_hw"}, 8'(IDEHWENn), 8'h3);
    chk({tag, "_le"}, 8'(IDELENn), 8'h3);
    chk({tag, "_dir"}, 8'(IDEDIR), 8'h0);
    chk({tag, "_burstn"}, 8'(BURSTn), 8'h1);
    chk({tag, "_lastn"}, 8'(LASTn), 8'h1);
    chk({tag, "_beat"}, 8'(BEAT), 8'h0);
    chk({tag, "_busdir"}, 8'(BUSDIR), 8'h0);
    chk({tag, "_busoen"}, 8'(BUSOEn), 8'h0);
    chk({tag, "_busy"}, 8'(BUSY), 8'h0);
  endtask

  initial begin
    RESETn = 1'b0; ATA_ENn = 2'b11; RnW = 1'b1; TSn = 1'b1; TAn = 1'b1;
    SIZ = 2'b00; BGn = 1'b1;
    tick(); tick();
    chk_reset_vals("rst");
    RESETn = 1'b1;
    tick();

    // line burst, with a stray TSn mid-burst that must be ignored
    SIZ = 2'b11; TSn = 1'b0;
    tick();
    TSn = 1'b1;
    chk("bu_busy", 8'(BUSY), 8'h1);
    chk("bu_beat0", 8'(BEAT), 8'h0);
    chk("bu_burstn", 8'(BURSTn), 8'h0);
    chk("bu_lastn0", 8'(LASTn), 8'h1);
    TAn = 1'b0;
    tick();
    chk("bu_beat1", 8'(BEAT), 8'h1);
    chk("bu_lastn1", 8'(LASTn), 8'h1);
    TSn = 1'b0; SIZ = 2'b10;
    tick();
    TSn = 1'b1; SIZ = 2'b11;
    chk("bu_beat2", 8'(BEAT), 8'h2);
    chk("bu_burstn2", 8'(BURSTn), 8'h0);
    chk("bu_lastn2", 8'(LASTn), 8'h1);
    tick();
    chk("bu_beat3", 8'(BEAT), 8'h3);
    chk("bu_lastn3", 8'(LASTn), 8'h0);
    chk("bu_busy3", 8'(BUSY), 8'h1);
    tick();
    TAn = 1'b1;
    chk("bu_end_busy", 8'(BUSY), 8'h0);
    chk("bu_end_burstn", 8'(BURSTn), 8'h1);
    chk("bu_end_lastn", 8'(LASTn), 8'h1);
    chk("bu_end_beat", 8'(BEAT), 8'h0);

    // TAn while idle is ignored
    TAn = 1'b0;
    tick();
    TAn = 1'b1;
    chk("idle_ta_busy", 8'(BUSY), 8'h0);
    chk("idle_ta_beat", 8'(BEAT), 8'h0);

    // single-beat cycle
    SIZ = 2'b10; TSn = 1'b0;
    tick();
    TSn = 1'b1;
    chk("sb_busy", 8'(BUSY), 8'h1);
    chk("sb_burstn", 8'(BURSTn), 8'h1);
    chk("sb_lastn", 8'(LASTn), 8'h0);
    tick();
    chk("sb_busy_wait", 8'(BUSY), 8'h1);
    chk("sb_lastn_wait", 8'(LASTn), 8'h0);
    TAn = 1'b0;
    tick();
    TAn = 1'b1;
    chk("sb_end_busy", 8'(BUSY), 8'h0);
    chk("sb_end_lastn", 8'(LASTn), 8'h1);

    // reset mid-burst with an active ATA write
    ATA_ENn = 2'b10; RnW = 1'b0; SIZ = 2'b11; TSn = 1'b0;
    tick();
    TSn = 1'b1; TAn = 1'b0;
    tick(); tick();
    chk("mr_beat2", 8'(BEAT), 8'h2);
    chk("mr_hw", 8'(IDEHWENn), 8'h2);
    chk("mr_dir", 8'(IDEDIR), 8'h1);
    TAn = 1'b1; ATA_ENn = 2'b11;
    RESETn = 1'b0;
    #2;
    chk_reset_vals("mr");
    tick();
    RESETn = 1'b1;
    tick();
    chk("mr_post_busy", 8'(BUSY), 8'h0);
    chk("mr_post_hw", 8'(IDEHWENn), 8'h3);

    // channel 0 read -> write -> channel 1 write -> invalid select
    ATA_ENn = 2'b10; RnW = 1'b1;
    tick();
    chk("at_rd_hr", 8'(IDEHRENn), 8'h2);
    chk("at_rd_hw", 8'(IDEHWENn), 8'h3);
    chk("at_rd_le", 8'(IDELENn), 8'h2);
    chk("at_rd_dir", 8'(IDEDIR), 8'h0);
    RnW = 1'b0;
    tick();
    chk("at_gap_hr", 8'(IDEHRENn), 8'h3);
    chk("at_gap_hw", 8'(IDEHWENn), 8'h3);
    chk("at_gap_le", 8'(IDELENn), 8'h3);
    chk("at_gap_dir", 8'(IDEDIR), 8'h1);
    tick();
    chk("at_wr_hw", 8'(IDEHWENn), 8'h2);
    chk("at_wr_hr", 8'(IDEHRENn), 8'h3);
    chk("at_wr_le", 8'(IDELENn), 8'h2);
    ATA_ENn = 2'b01;
    tick();
    chk("at_chg_gap_hw", 8'(IDEHWENn), 8'h3);
    chk("at_chg_gap_le", 8'(IDELENn), 8'h3);
    tick();
    chk("at_ch1_hw", 8'(IDEHWENn), 8'h1);
    chk("at_ch1_le", 8'(IDELENn), 8'h1);
    ATA_ENn = 2'b00;
    tick();
    chk("at_multi_gap_hw", 8'(IDEHWENn), 8'h3);
    tick();
    chk("at_multi_hw", 8'(IDEHWENn), 8'h3);
    chk("at_multi_le", 8'(IDELENn), 8'h3);
    chk("at_multi_dir", 8'(IDEDIR), 8'h1);
    ATA_ENn = 2'b11;
    tick();

    // grant coincident with a burst start: handover waits for the burst
    ATA_ENn = 2'b10; RnW = 1'b1;
    tick();
    chk("gr_hr", 8'(IDEHRENn), 8'h2);
    chk("gr_dir", 8'(IDEDIR), 8'h0);
    TSn = 1'b0; SIZ = 2'b11; BGn = 1'b0;
    tick();
    TSn = 1'b1; TAn = 1'b0;
    chk("gr_busy", 8'(BUSY), 8'h1);
    chk("gr_busoen0", 8'(BUSOEn), 8'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gr_burst_busoen", 8'(BUSOEn), 8'h0);
      chk("gr_burst_busdir", 8'(BUSDIR), 8'h0);
    end
    tick();
    TAn = 1'b1;
    chk("gr_done_busy", 8'(BUSY), 8'h0);
    chk("gr_done_busoen", 8'(BUSOEn), 8'h0);
    tick();
    chk("gr_turn1_busoen", 8'(BUSOEn), 8'h1);
    chk("gr_turn1_busdir", 8'(BUSDIR), 8'h0);
    chk("gr_turn1_hr", 8'(IDEHRENn), 8'h3);
    chk("gr_turn1_le", 8'(IDELENn), 8'h3);
    tick();
    chk("gr_turn2_busoen", 8'(BUSOEn), 8'h1);
    tick();
    chk("gr_pci_busoen", 8'(BUSOEn), 8'h0);
    chk("gr_pci_busdir", 8'(BUSDIR), 8'h1);
    chk("gr_pci_hr", 8'(IDEHRENn), 8'h3);
    tick();
    chk("gr_pci_hold_hr", 8'(IDEHRENn), 8'h3);
    chk("gr_pci_hold_busdir", 8'(BUSDIR), 8'h1);
    BGn = 1'b1;
    tick();
    chk("gr_back1_busoen", 8'(BUSOEn), 8'h1);
    chk("gr_back1_busdir", 8'(BUSDIR), 8'h1);
    tick();
    chk("gr_back2_busoen", 8'(BUSOEn), 8'h1);
    tick();
    chk("gr_cpu_busoen", 8'(BUSOEn), 8'h0);
    chk("gr_cpu_busdir", 8'(BUSDIR), 8'h0);
    tick();
    chk("gr_cpu_hr", 8'(IDEHRENn), 8'h2);
    ATA_ENn = 2'b11;
    tick(); tick();

    // grant released during TURN_PCI: turn completes, then a full reverse turn
    BGn = 1'b0;
    tick();
    chk("ab_t1_busoen", 8'(BUSOEn), 8'h1);
    chk("ab_t1_busdir", 8'(BUSDIR), 8'h0);
    BGn = 1'b1;
    tick();
    chk("ab_t2_busoen", 8'(BUSOEn), 8'h1);
    chk("ab_t2_busdir", 8'(BUSDIR), 8'h0);
    tick();
    chk("ab_pci_busoen", 8'(BUSOEn), 8'h0);
    chk("ab_pci_busdir", 8'(BUSDIR), 8'h1);
    tick();
    chk("ab_r1_busoen", 8'(BUSOEn), 8'h1);
    chk("ab_r1_busdir", 8'(BUSDIR), 8'h1);
    tick();
    chk("ab_r2_busoen", 8'(BUSOEn), 8'h1);
    tick();
    chk("ab_cpu_busoen", 8'(BUSOEn), 8'h0);
    chk("ab_cpu_busdir", 8'(BUSDIR), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
